axi2apb_ctrl: RTL

//  APB master sequencer of the AXI-to-APB bridge. Takes the head entry of the

---
 rtl/axi2apb_ctrl.sv | 92 +++++++++
 1 files changed

// File: rtl/axi2apb_ctrl.sv
// APB master sequencer for the AXI-to-APB bridge: runs one SETUP/ACCESS
// transfer per command FIFO head entry, then pops it once the AXI response side completes.
module axi2apb_ctrl #(
  parameter int unsigned ADDR_BITS = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_empty,
  input  logic                 cmd_read,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  output logic                 cmd_pop,
  input  logic                 WVALID,
  input  logic                 finish_wr,
  input  logic                 finish_rd,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [ADDR_BITS-1:0] paddr,
  input  logic                 pready
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SETUP     = 2'd1,
    ACCESS    = 2'd2,
    WAIT_RESP = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic                   psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_BITS-1:0]   paddr_nxt;
  logic                   start, finish_sel;

  // A write may only begin once its data beat is available.
  assign start      = ~cmd_empty & (cmd_read | WVALID);
  assign finish_sel = pwrite ? finish_wr : finish_rd;

  // State and registered APB outputs share one register process.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
    end else begin
      state   <= state_nxt;
      psel    <= psel_nxt;
      penable <= penable_nxt;
      pwrite  <= pwrite_nxt;
      paddr   <= paddr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (start)      state_nxt = SETUP;
      SETUP:                     state_nxt = ACCESS;
      ACCESS:    if (pready)     state_nxt = WAIT_RESP;
      WAIT_RESP: if (finish_sel) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    psel_nxt    = psel;
    penable_nxt = penable;
    pwrite_nxt  = pwrite;
    paddr_nxt   = paddr;
    cmd_pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          psel_nxt   = 1'b1;
          pwrite_nxt = ~cmd_read;
          paddr_nxt  = cmd_addr;
        end
      end
      SETUP: penable_nxt = 1'b1;
      ACCESS: begin
        if (pready) begin
          psel_nxt    = 1'b0;
          penable_nxt = 1'b0;
        end
      end
      WAIT_RESP: cmd_pop = finish_sel;
      default: ;
    endcase
  end

endmodule
